// File: rtl/tile_addr_seq_pkg.sv
// Shared definitions for the tile address sequencer: FSM encoding and the
// direction codes used by the team up/down step counter.
package tile_addr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tile_addr_seq_step_counter.sv
// Loadable up/down step counter; load has priority over the count enable.
module step_counter
    import tile_addr_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         mode,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_o <= '0;
        end else if (load) begin
            cnt_o <= load_val;
        end else if (en) begin
            cnt_o <= (mode == DIR_UP) ? cnt_o + W'(1) : cnt_o - W'(1);
        end
    end

endmodule

// File: rtl/tile_addr_seq.sv
// Walks a num_rows x num_cols SRAM tile and issues one read address per
// accepted valid/ready beat; every output comes straight from a register.
module tile_addr_seq
    import tile_addr_seq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [COL_W-1:0]  num_cols,
    input  logic              reverse,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid,
    output logic              row_last,
    output logic              busy,
    output logic              done
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] row_base, stride_q;
    logic [ROW_W-1:0]  rows_q, row_idx;
    logic [COL_W-1:0]  cols_q, col_idx;
    logic [COL_W-1:0]  col_start_in, col_start_q;
    logic              rev_q;
    logic              start_acc, beat, col_end, col_next_end, tile_last;
    logic [ADDR_W-1:0] addr_next;
    logic              row_last_next;

    assign start_acc    = (state == IDLE) && start;
    assign beat         = (state == RUN) && addr_ready;
    assign col_start_in = reverse ? num_cols - COL_W'(1) : '0;
    assign col_start_q  = rev_q ? cols_q - COL_W'(1) : '0;
    assign col_end      = rev_q ? (col_idx == '0) : (col_idx == cols_q - COL_W'(1));
    // Whether the column reached by a non-row-end step is the row-end column.
    assign col_next_end = rev_q ? (col_idx == COL_W'(1)) : (col_idx == cols_q - COL_W'(2));
    assign tile_last    = col_end && (row_idx == rows_q - ROW_W'(1));

    step_counter #(.W(COL_W)) u_col_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc || (beat && col_end)),
        .load_val (start_acc ? col_start_in : col_start_q),
        .en       (beat),
        .mode     (rev_q ? DIR_DOWN : DIR_UP),
        .cnt_o    (col_idx)
    );

    step_counter #(.W(ROW_W)) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val ('0),
        .en       (beat && col_end),
        .mode     (DIR_UP),
        .cnt_o    (row_idx)
    );

    // Tile configuration and row base are pure data: no reset needed.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            stride_q <= stride;
            rows_q   <= num_rows;
            cols_q   <= num_cols;
            rev_q    <= reverse;
            row_base <= base_addr;
        end else if (beat && col_end) begin
            row_base <= row_base + stride_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        addr_next     = addr_o;
        row_last_next = row_last;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next    = (num_rows != '0 && num_cols != '0) ? RUN : DONE;
                    addr_next     = base_addr + ADDR_W'(col_start_in);
                    row_last_next = (num_cols == COL_W'(1)) && (num_rows != '0);
                end
            end
            RUN: begin
                if (beat) begin
                    if (tile_last) begin
                        state_next    = DONE;
                        row_last_next = 1'b0;
                    end else if (col_end) begin
                        addr_next     = row_base + stride_q + ADDR_W'(col_start_q);
                        row_last_next = (cols_q == COL_W'(1));
                    end else begin
                        addr_next     = rev_q ? addr_o - ADDR_W'(1) : addr_o + ADDR_W'(1);
                        row_last_next = col_next_end;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_o     <= '0;
            addr_valid <= 1'b0;
            row_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            addr_o     <= addr_next;
            addr_valid <= (state_next == RUN);
            row_last   <= row_last_next;
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
        end
    end

endmodule
